// File: rtl/array_serializer_pkg.sv
// array_serializer_pkg: shared state type and index-width helper
// for the array flatten serializer.
package array_serializer_pkg;

    typedef enum logic {IDLE, STREAM} ser_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/array_index_counter.sv
// array_index_counter: 2-D wrap counter walking a ROWS x COLS grid
// in row- or column-major order, flagging the final element.
module array_index_counter
    import array_serializer_pkg::*;
#(
    parameter int ROWS      = 3,
    parameter int COLS      = 2,
    parameter bit COL_MAJOR = 1'b0,
    localparam int RW = idx_w(ROWS),
    localparam int CW = idx_w(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          is_last
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic row_end;
    logic col_end;

    assign row_end = (row == ROW_MAX);
    assign col_end = (col == COL_MAX);
    assign is_last = row_end & col_end;

    // The final element wraps both axes, so the grid restarts at [0][0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (COL_MAJOR) begin
                row <= row_end ? '0 : row + 1'b1;
                if (row_end)
                    col <= col_end ? '0 : col + 1'b1;
            end else begin
                col <= col_end ? '0 : col + 1'b1;
                if (col_end)
                    row <= row_end ? '0 : row + 1'b1;
            end
        end
    end

endmodule

// File: rtl/array_flatten_serializer.sv
// array_flatten_serializer: streams a packed ROWS x COLS bundle one tagged
// element per beat. Define ARRAY_SERIALIZER_COL_MAJOR_EN for column-major order.
module array_flatten_serializer
    import array_serializer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ROWS  = 3,
    parameter int COLS  = 2,
    localparam int RW = idx_w(ROWS),
    localparam int CW = idx_w(COLS),
    localparam int N  = ROWS * COLS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [RW-1:0]      out_row,
    output logic [CW-1:0]      out_col,
    output logic               out_last
);

`ifdef ARRAY_SERIALIZER_COL_MAJOR_EN
    localparam bit COL_MAJOR = 1'b1;
`else
    localparam bit COL_MAJOR = 1'b0;
`endif

    ser_state_t         state;
    logic               valid_q;
    logic [N*WIDTH-1:0] bundle_q;
    logic               is_last;
    logic               out_hs;
    logic               last_hs;
    logic               in_hs;
    logic [WIDTH-1:0]   elem [ROWS][COLS];

    assign out_hs   = valid_q & out_ready;
    assign last_hs  = out_hs & is_last;
    assign in_ready = (state == IDLE) | last_hs;
    assign in_hs    = in_valid & in_ready;

    array_index_counter #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .COL_MAJOR (COL_MAJOR)
    ) u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (in_hs),
        .advance (out_hs),
        .row     (out_row),
        .col     (out_col),
        .is_last (is_last)
    );

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign elem[r][c] = bundle_q[(r*COLS+c)*WIDTH +: WIDTH];
        end
    end

    assign out_valid = valid_q;
    assign out_data  = elem[out_row][out_col];
    assign out_last  = valid_q & is_last;

    // A capture on the last beat keeps STREAM alive with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            if (in_hs)
                bundle_q <= in_data;
            unique case (state)
                IDLE: begin
                    if (in_hs) begin
                        state   <= STREAM;
                        valid_q <= 1'b1;
                    end
                end
                STREAM: begin
                    if (last_hs && !in_valid) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_flatten_serializer.sv
// Bench for array_flatten_serializer: queue-based reference model,
// a 3x2 instance and a degenerate 1x1 instance.
module tb_array_flatten_serializer;
    import array_serializer_pkg::*;

    localparam int W  = 4;
    localparam int R  = 3;
    localparam int C  = 2;
    localparam int N  = R * C;
    localparam int RW = idx_w(R);
    localparam int CW = idx_w(C);

    typedef struct {
        logic [W-1:0] d;
        int           r;
        int           c;
        bit           l;
        int           cyc;
    } beat_t;

    logic           clk = 0;
    logic           rst_n = 1;
    logic           in_valid = 0;
    logic [N*W-1:0] in_data = '0;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready = 1;
    logic [W-1:0]   out_data;
    logic [RW-1:0]  out_row;
    logic [CW-1:0]  out_col;
    logic           out_last;

    logic           d_in_valid = 0;
    logic [W-1:0]   d_in_data = '0;
    logic           d_in_ready;
    logic           d_out_valid;
    logic           d_out_ready = 1;
    logic [W-1:0]   d_out_data;
    logic [0:0]     d_out_row;
    logic [0:0]     d_out_col;
    logic           d_out_last;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stat_ir = 0;
    bit rdy_rand = 0;
    bit acc = 0;
    bit d_acc = 0;

    beat_t          mq[$];
    beat_t          dq[$];
    beat_t          log_q[$];
    beat_t          dlog_q[$];
    logic [N*W-1:0] drv_q[$];
    logic [W-1:0]   ddrv_q[$];

    bit           p_hold = 0;
    logic [W-1:0] p_d;
    logic [RW-1:0] p_r;
    logic [CW-1:0] p_c;
    logic         p_l;

    array_flatten_serializer #(.WIDTH(W), .ROWS(R), .COLS(C)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    array_flatten_serializer #(.WIDTH(W), .ROWS(1), .COLS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
        .out_row(d_out_row), .out_col(d_out_col), .out_last(d_out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected beat order for one bundle, straight from the traversal rule.
    task automatic model_push(input logic [N*W-1:0] bun);
        beat_t b;
`ifdef ARRAY_SERIALIZER_COL_MAJOR_EN
        for (int c = 0; c < C; c++)
            for (int r = 0; r < R; r++) begin
`else
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
`endif
                b.d = bun[(r*C+c)*W +: W];
                b.r = r;
                b.c = c;
                b.l = (r == R-1) && (c == C-1);
                b.cyc = 0;
                mq.push_back(b);
            end
    endtask

    function automatic logic [N*W-1:0] mk(input int base);
        logic [N*W-1:0] v;
        v = '0;
        for (int e = 0; e < N; e++)
            v[e*W +: W] = W'(base + e);
        return v;
    endfunction

    // Compare process: checks every cycle against the model, then steps it.
    always @(negedge clk) begin
        beat_t b;
        cyc++;
        acc = 0;
        d_acc = 0;
        if (!rst_n) begin
            mq.delete();
            dq.delete();
            p_hold = 0;
        end else begin
            chk("out_valid", out_valid, mq.size() != 0);
            chk("in_ready", in_ready,
                mq.size() == 0 || (out_ready && mq[0].l));
            if (mq.size() != 0) begin
                chk("out_data", out_data, mq[0].d);
                chk("out_row", out_row, mq[0].r);
                chk("out_col", out_col, mq[0].c);
                chk("out_last", out_last, mq[0].l);
            end
            if (p_hold) begin
                chk("hold_data", out_data, p_d);
                chk("hold_tags", {out_row, out_col, out_last}, {p_r, p_c, p_l});
            end
            p_hold = out_valid && !out_ready;
            p_d = out_data;
            p_r = out_row;
            p_c = out_col;
            p_l = out_last;
            if (out_valid && in_ready)
                stat_ir++;
            if (out_valid && out_ready && mq.size() != 0) begin
                b = mq.pop_front();
                b.cyc = cyc;
                log_q.push_back(b);
            end
            if (in_valid && in_ready) begin
                acc = 1;
                model_push(in_data);
            end

            chk("d_out_valid", d_out_valid, dq.size() != 0);
            chk("d_in_ready", d_in_ready,
                dq.size() == 0 || (d_out_ready && dq[0].l));
            if (dq.size() != 0) begin
                chk("d_out_data", d_out_data, dq[0].d);
                chk("d_tags", {d_out_row, d_out_col, d_out_last}, 3'b001);
            end
            if (d_out_valid && d_out_ready && dq.size() != 0) begin
                b = dq.pop_front();
                b.cyc = cyc;
                dlog_q.push_back(b);
            end
            if (d_in_valid && d_in_ready) begin
                d_acc = 1;
                b.d = d_in_data;
                b.r = 0;
                b.c = 0;
                b.l = 1;
                b.cyc = 0;
                dq.push_back(b);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            drv_q.delete();
            ddrv_q.delete();
        end else begin
            if (acc)
                void'(drv_q.pop_front());
            if (d_acc)
                void'(ddrv_q.pop_front());
        end
        in_valid = drv_q.size() != 0;
        in_data = in_valid ? drv_q[0] : (N*W)'({$urandom(), $urandom()});
        out_ready = rdy_rand ? 1'($urandom()) : 1'b1;
        d_in_valid = ddrv_q.size() != 0;
        d_in_data = d_in_valid ? ddrv_q[0] : W'($urandom());
    end

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((drv_q.size() != 0 || mq.size() != 0 || ddrv_q.size() != 0
                || dq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout: got %0d cycles expected < %0d", name, n, budget);
        end
    endtask

    initial begin
        int exp_d[N];
        int exp_r[N];
        int exp_c[N];
        int ir0;
        int n;
`ifdef ARRAY_SERIALIZER_COL_MAJOR_EN
        exp_d = '{0, 2, 4, 1, 3, 5};
        exp_r = '{0, 1, 2, 0, 1, 2};
        exp_c = '{0, 0, 0, 1, 1, 1};
`else
        exp_d = '{0, 1, 2, 3, 4, 5};
        exp_r = '{0, 0, 1, 1, 2, 2};
        exp_c = '{0, 1, 0, 1, 0, 1};
`endif
        #1 rst_n = 0;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_tags", {out_row, out_col, out_last}, 0);
        chk("rst_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #2 rst_n = 1;

        log_q.delete();
        drv_q.push_back(mk(0));
        wait_idle(100, "ordering");
        chk("ord_count", log_q.size(), N);
        for (int i = 0; i < N && i < log_q.size(); i++) begin
            chk("ord_data", log_q[i].d, exp_d[i]);
            chk("ord_row", log_q[i].r, exp_r[i]);
            chk("ord_col", log_q[i].c, exp_c[i]);
            chk("ord_last", log_q[i].l, i == N-1);
        end

        log_q.delete();
        ir0 = stat_ir;
        drv_q.push_back(mk(0));
        drv_q.push_back(mk(10));
        wait_idle(100, "b2b");
        chk("b2b_count", log_q.size(), 2*N);
        if (log_q.size() == 2*N) begin
            chk("b2b_contig", log_q[2*N-1].cyc - log_q[0].cyc, 2*N-1);
            chk("b2b_first_b", log_q[N].d, 4'hA);
            chk("b2b_last_b", log_q[2*N-1].d, 4'hF);
        end
        chk("b2b_ready_pulses", stat_ir - ir0, 2);

        rdy_rand = 1;
        log_q.delete();
        for (int i = 0; i < 10; i++)
            drv_q.push_back((N*W)'({$urandom(), $urandom()}));
        wait_idle(2000, "backpressure");
        chk("bp_count", log_q.size(), 10*N);
        for (int k = 0; k < 3; k++) begin
            drv_q.push_back((N*W)'({$urandom(), $urandom()}));
            wait_idle(200, "bp_gap");
            repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        rdy_rand = 0;

        log_q.delete();
        drv_q.push_back(mk(3));
        n = 0;
        while (log_q.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached", log_q.size() >= 2, 1);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_tags", {out_row, out_col, out_last}, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk);
        #2;
        chk("post_rst_idle", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);
        log_q.delete();
        drv_q.push_back(mk(0));
        wait_idle(100, "post_rst");
        chk("post_rst_count", log_q.size(), N);
        if (log_q.size() != 0)
            chk("post_rst_first", log_q[0].d, 0);

        dlog_q.delete();
        for (int i = 0; i < 4; i++)
            ddrv_q.push_back(W'(i + 5));
        wait_idle(100, "degen");
        chk("deg_count", dlog_q.size(), 4);
        if (dlog_q.size() == 4) begin
            chk("deg_rate", dlog_q[3].cyc - dlog_q[0].cyc, 3);
            chk("deg_data0", dlog_q[0].d, 5);
            chk("deg_data3", dlog_q[3].d, 8);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
